dac_serial_gen: RTL and testbench
=================================

DAC_SERIAL_GEN -- requirements
Module: dac_serial_gen

Interface
REQ-001 Parameters: DWIDTH, default 12, DAC code width (4..16); FRAME_LEN, default 16, dclk cycles per frame (>= DWIDTH+1); LSB_FIRST, default 0, serial bit order (0 = MSB first).
REQ-002 Ports, one per line (name, direction, width, meaning):
- dclk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  frame generation enable.
- mode  in  2  waveform: 0 HOLD, 1 SAW_UP, 2 SAW_DN, 3 TRI.
- stepsize  in  DWIDTH  code increment per frame.
- lo_lim  in  DWIDTH  lower code limit.
- hi_lim  in  DWIDTH  upper code limit.
- dce_n  out  1  DAC latch strobe; low during frame cycle 0.
- dout  out  1  serial data.
- chirp_n  out  1  low one cycle on wrap or turnaround.
- sample  out  DWIDTH  code of the current frame.

Function
REQ-003 A frame counter fcnt runs 0..FRAME_LEN-1; a frame boundary is the edge that enters fcnt=0.
REQ-004 At each boundary, mode, stepsize, lo_lim and hi_lim are sampled; inputs changing mid-frame have no effect until the next boundary.
REQ-005 At each boundary, next code is computed in DWIDTH+1-bit arithmetic; code register, sample and shift register all load that value on the same edge.
REQ-006 If current code < lo_lim or > hi_lim: next = lo_lim, direction = up, no chirp; this rule overrides every mode.
REQ-007 If lo_lim >= hi_lim: next = lo_lim; no chirp.
REQ-008 HOLD: next = code.
REQ-009 SAW_UP: sum = code+step; if sum > hi_lim then next = lo_lim with chirp, else next = sum.
REQ-010 SAW_DN: diff = code-step, signed; if diff < lo_lim then next = hi_lim with chirp, else next = diff.
REQ-011 TRI going up: if code+step > hi_lim then next = hi_lim, direction = down, chirp.
REQ-012 TRI going down: if code-step < lo_lim then next = lo_lim, direction = up, chirp. Otherwise TRI moves by step.
REQ-013 stepsize = 0: code does not change and chirp is never asserted.
REQ-014 A value exactly equal to a limit is in range and causes no wrap.
REQ-015 dce_n = 0 and chirp_n (when flagged) = 0 during the fcnt=0 cycle only; both are registered outputs.
REQ-016 dout presents code bits during fcnt 0..DWIDTH-1, MSB-first (or LSB-first if LSB_FIRST=1); dout = 0 for fcnt DWIDTH..FRAME_LEN-1.
REQ-017 en deasserted mid-frame: the current frame completes. fcnt then holds at FRAME_LEN-1 with dce_n=1, dout=0, and code and direction held.
REQ-018 en asserted while idle: the next edge is a frame boundary.

Reset
REQ-019 rst is sampled on the dclk rising edge only and overrides en.
REQ-020 On reset: fcnt = FRAME_LEN-1, code = 0, sample = 0, shift register = 0, direction = up, dce_n = 1, chirp_n = 1, dout = 0.
REQ-021 rst mid-frame aborts the frame immediately; there is no partial-frame completion.

Structure
REQ-022 Shared package dac_pkg holds the mode encoding constants (HOLD, SAW_UP, SAW_DN, TRI) and the direction encoding.
REQ-023 One sub-module, dac_code_gen, holds the next-code/limit/direction logic and the direction register. The top module holds fcnt, the shift register and output strobes.

Verification (DWIDTH=8, FRAME_LEN=10, LSB_FIRST=0)
REQ-024 rst high 3 cycles, en=1 -> dce_n=1, chirp_n=1, dout=0, sample=0x00 throughout; first dce_n low on the edge after rst falls.
REQ-025 SAW_UP, lo=0x00, hi=0xF0, step=0x40 -> sample 0x40, 0x80, 0xC0, 0x00 (chirp_n low with that frame's dce_n), 0x40; dce_n period 10 cycles.
REQ-026 TRI, lo=0x10, hi=0xE0, step=0x60, from reset -> 0x10 (clamp, no chirp), 0x70, 0xD0, 0xE0 (chirp), 0x80, 0x20, 0x10 (chirp), 0x70.
REQ-027 SAW_DN, lo=0x00, hi=0xFF, step=0xFF -> 0xFF (chirp), 0x00, 0xFF (chirp). Then switch to HOLD -> 0xFF repeated, no chirp.
REQ-028 Serial check: frame code 0xA5 -> dout 1,0,1,0,0,1,0,1 at fcnt 0..7, then 0,0. Same code with LSB_FIRST=1 -> 1,0,1,0,0,1,0,1 reversed per bit order (LSB first).
REQ-029 en dropped at fcnt=3 -> frame finishes, dce_n stays 1; en raised -> dce_n low next edge, code resumes from held value. rst at fcnt=4 -> reset values on the following edge.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared encodings for the serial DAC waveform generator: waveform modes and
// triangle sweep direction.
package dac_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SAW_UP = 2'd1,
    SAW_DN = 2'd2,
    TRI    = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/dac_code_gen.sv
// Next-code computation for one frame: limit clamping, sawtooth wrap, triangle
// turnaround and the triangle direction register.
module dac_code_gen
  import dac_pkg::*;
#(
  parameter int DWIDTH = 12
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              i_adv,
  input  logic [1:0]        i_mode,
  input  logic [DWIDTH-1:0] i_step,
  input  logic [DWIDTH-1:0] i_lo,
  input  logic [DWIDTH-1:0] i_hi,
  input  logic [DWIDTH-1:0] i_code,
  output logic [DWIDTH-1:0] o_next_code,
  output logic              o_chirp
);

  dir_e              r_dir;
  dir_e              w_dir_nxt;
  mode_e             w_mode;
  logic [DWIDTH:0]   w_sum;
  logic [DWIDTH:0]   w_diff;
  logic              w_sum_over;
  logic              w_diff_under;
  logic [DWIDTH-1:0] w_next;
  logic              w_chirp;

  assign w_mode = mode_e'(i_mode);
  assign w_sum  = {1'b0, i_code} + {1'b0, i_step};
  assign w_diff = {1'b0, i_code} - {1'b0, i_step};

  // The extra top bit of w_diff is the sign of code-step.
  assign w_sum_over   = w_sum > {1'b0, i_hi};
  assign w_diff_under = w_diff[DWIDTH] || (w_diff[DWIDTH-1:0] < i_lo);

  always_comb begin
    w_next    = i_code;
    w_chirp   = 1'b0;
    w_dir_nxt = r_dir;
    if ((i_code < i_lo) || (i_code > i_hi)) begin
      w_next    = i_lo;
      w_dir_nxt = DIR_UP;
    end else if (i_lo >= i_hi) begin
      w_next = i_lo;
    end else if (i_step == '0) begin
      w_next = i_code;
    end else begin
      case (w_mode)
        HOLD: w_next = i_code;
        SAW_UP: begin
          if (w_sum_over) begin
            w_next  = i_lo;
            w_chirp = 1'b1;
          end else begin
            w_next = w_sum[DWIDTH-1:0];
          end
        end
        SAW_DN: begin
          if (w_diff_under) begin
            w_next  = i_hi;
            w_chirp = 1'b1;
          end else begin
            w_next = w_diff[DWIDTH-1:0];
          end
        end
        TRI: begin
          if (r_dir == DIR_UP) begin
            if (w_sum_over) begin
              w_next    = i_hi;
              w_dir_nxt = DIR_DN;
              w_chirp   = 1'b1;
            end else begin
              w_next = w_sum[DWIDTH-1:0];
            end
          end else begin
            if (w_diff_under) begin
              w_next    = i_lo;
              w_dir_nxt = DIR_UP;
              w_chirp   = 1'b1;
            end else begin
              w_next = w_diff[DWIDTH-1:0];
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      r_dir <= DIR_UP;
    end else if (i_adv) begin
      r_dir <= w_dir_nxt;
    end
  end

  assign o_next_code = w_next;
  assign o_chirp     = w_chirp;

endmodule

// File: rtl/dac_serial_gen.sv
// Serial DAC waveform generator: frame counter, code register, serialiser and
// registered latch/chirp strobes around the dac_code_gen next-code logic.
module dac_serial_gen
  import dac_pkg::*;
#(
  parameter int DWIDTH    = 12,
  parameter int FRAME_LEN = 16,
  parameter int LSB_FIRST = 0
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DWIDTH-1:0] stepsize,
  input  logic [DWIDTH-1:0] lo_lim,
  input  logic [DWIDTH-1:0] hi_lim,
  output logic              dce_n,
  output logic              dout,
  output logic              chirp_n,
  output logic [DWIDTH-1:0] sample
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] DATA_LAST = FW'(DWIDTH - 1);

  logic [FW-1:0]     r_fcnt;
  logic [DWIDTH-1:0] r_code;
  logic [DWIDTH-1:0] r_shift;
  logic              r_dce_n;
  logic              r_chirp_n;
  logic              r_dout;

  logic              w_boundary;
  logic [DWIDTH-1:0] w_next;
  logic              w_chirp;
  logic [DWIDTH-1:0] w_load;

  // Idle parks the counter on its last value, so enabling makes the very next
  // edge a frame boundary.
  assign w_boundary = (r_fcnt == FCNT_LAST) && en;

  dac_code_gen #(
    .DWIDTH(DWIDTH)
  ) u_code_gen (
    .dclk       (dclk),
    .rst        (rst),
    .i_adv      (w_boundary),
    .i_mode     (mode),
    .i_step     (stepsize),
    .i_lo       (lo_lim),
    .i_hi       (hi_lim),
    .i_code     (r_code),
    .o_next_code(w_next),
    .o_chirp    (w_chirp)
  );

  // Shift register always emits from its MSB; LSB-first order is a bit
  // reversal at load time.
  always_comb begin
    w_load = w_next;
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < DWIDTH; i++) begin
        w_load[i] = w_next[DWIDTH-1-i];
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      r_fcnt    <= FCNT_LAST;
      r_code    <= '0;
      r_shift   <= '0;
      r_dce_n   <= 1'b1;
      r_chirp_n <= 1'b1;
      r_dout    <= 1'b0;
    end else if (r_fcnt == FCNT_LAST) begin
      if (en) begin
        r_fcnt    <= '0;
        r_code    <= w_next;
        r_shift   <= w_load;
        r_dce_n   <= 1'b0;
        r_chirp_n <= ~w_chirp;
        r_dout    <= w_load[DWIDTH-1];
      end else begin
        r_dce_n   <= 1'b1;
        r_chirp_n <= 1'b1;
        r_dout    <= 1'b0;
      end
    end else begin
      r_fcnt    <= r_fcnt + FW'(1);
      r_dce_n   <= 1'b1;
      r_chirp_n <= 1'b1;
      if (r_fcnt < DATA_LAST) begin
        r_shift <= r_shift << 1;
        r_dout  <= r_shift[DWIDTH-2];
      end else begin
        r_dout <= 1'b0;
      end
    end
  end

  assign dce_n   = r_dce_n;
  assign chirp_n = r_chirp_n;
  assign dout    = r_dout;
  assign sample  = r_code;

endmodule

// File: tb/tb_dac_serial_gen.sv
// Directed bench for dac_serial_gen (DWIDTH=8, FRAME_LEN=10); one MSB-first and
// one LSB-first instance share the same stimulus.
module tb_dac_serial_gen;

  typedef struct {
    logic       rst_first;
    logic [1:0] mode;
    logic [7:0] step;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] exp_sample;
    logic       exp_chirp_n;
    int         exp_gap;
  } vec_t;

  logic       dclk = 1'b0;
  logic       rst  = 1'b1;
  logic       en   = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [7:0] stepsize = 8'h00;
  logic [7:0] lo_lim   = 8'h00;
  logic [7:0] hi_lim   = 8'h00;

  logic       dce_n_m, dout_m, chirp_n_m;
  logic [7:0] sample_m;
  logic       dce_n_l, dout_l, chirp_n_l;
  logic [7:0] sample_l;

  int n_checks = 0;
  int n_errors = 0;

  vec_t       vecs[$];
  logic [7:0] ser_codes[2];

  dac_serial_gen #(.DWIDTH(8), .FRAME_LEN(10), .LSB_FIRST(0)) u_dut_m (
    .dclk(dclk), .rst(rst), .en(en), .mode(mode), .stepsize(stepsize),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .dce_n(dce_n_m), .dout(dout_m),
    .chirp_n(chirp_n_m), .sample(sample_m)
  );

  dac_serial_gen #(.DWIDTH(8), .FRAME_LEN(10), .LSB_FIRST(1)) u_dut_l (
    .dclk(dclk), .rst(rst), .en(en), .mode(mode), .stepsize(stepsize),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .dce_n(dce_n_l), .dout(dout_l),
    .chirp_n(chirp_n_l), .sample(sample_l)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge dclk);
      chk("rst_dce_n", dce_n_m, 1);
      chk("rst_chirp_n", chirp_n_m, 1);
      chk("rst_dout", dout_m, 0);
      chk("rst_sample", sample_m, 0);
    end
    rst = 1'b0;
  endtask

  task automatic wait_boundary(output int n);
    n = 0;
    do begin
      @(negedge dclk);
      n++;
    end while (dce_n_m !== 1'b0 && n < 40);
    chk("boundary_seen", dce_n_m, 0);
  endtask

  initial begin
    int n;
    int lows;
    int highs;
    logic [7:0] code;

    ser_codes[0] = 8'hA5;
    ser_codes[1] = 8'h1E;

    // rst_first, mode, step, lo, hi, exp_sample, exp_chirp_n, exp_gap
    vecs.push_back('{1'b1, 2'd1, 8'h40, 8'h00, 8'hF0, 8'h40, 1'b1, 1});
    vecs.push_back('{1'b0, 2'd1, 8'h40, 8'h00, 8'hF0, 8'h80, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h40, 8'h00, 8'hF0, 8'hC0, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h40, 8'h00, 8'hF0, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h40, 8'h00, 8'hF0, 8'h40, 1'b1, 9});
    vecs.push_back('{1'b1, 2'd3, 8'h60, 8'h10, 8'hE0, 8'h10, 1'b1, 1});
    vecs.push_back('{1'b0, 2'd3, 8'h60, 8'h10, 8'hE0, 8'h70, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h60, 8'h10, 8'hE0, 8'hD0, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h60, 8'h10, 8'hE0, 8'hE0, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h60, 8'h10, 8'hE0, 8'h80, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h60, 8'h10, 8'hE0, 8'h20, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h60, 8'h10, 8'hE0, 8'h10, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h60, 8'h10, 8'hE0, 8'h70, 1'b1, 9});
    vecs.push_back('{1'b1, 2'd2, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0, 1});
    vecs.push_back('{1'b0, 2'd2, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd2, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd0, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h00, 8'h00, 8'hFF, 8'hFF, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h01, 8'h00, 8'hFF, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h10, 8'h00, 8'h10, 8'h10, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h10, 8'h00, 8'h10, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h10, 8'h30, 8'h30, 8'h30, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd1, 8'h10, 8'h30, 8'h30, 8'h30, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd2, 8'h10, 8'h40, 8'h80, 8'h40, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd2, 8'h10, 8'h40, 8'h80, 8'h80, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h10, 8'h40, 8'h80, 8'h80, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h10, 8'h40, 8'h80, 8'h70, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h40, 8'h40, 8'h80, 8'h40, 1'b0, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h40, 8'h40, 8'h80, 8'h80, 1'b1, 9});
    vecs.push_back('{1'b0, 2'd3, 8'h40, 8'h40, 8'h80, 8'h80, 1'b0, 9});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_first) do_reset();
      mode     = vecs[i].mode;
      stepsize = vecs[i].step;
      lo_lim   = vecs[i].lo;
      hi_lim   = vecs[i].hi;
      wait_boundary(n);
      chk($sformatf("v%0d_gap", i), n, vecs[i].exp_gap);
      chk($sformatf("v%0d_sample", i), sample_m, vecs[i].exp_sample);
      chk($sformatf("v%0d_chirp_n", i), chirp_n_m, vecs[i].exp_chirp_n);
      chk($sformatf("v%0d_sample_lsbf", i), sample_l, vecs[i].exp_sample);
      @(negedge dclk);
      chk($sformatf("v%0d_dce_n_f1", i), dce_n_m, 1);
      chk($sformatf("v%0d_chirp_n_f1", i), chirp_n_m, 1);
    end

    // Serial bit order on both instances.
    for (int c = 0; c < 2; c++) begin
      code = ser_codes[c];
      do_reset();
      mode     = 2'd1;
      lo_lim   = 8'h00;
      hi_lim   = 8'hFF;
      stepsize = code;
      wait_boundary(n);
      chk($sformatf("ser%0d_sample", c), sample_m, code);
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("ser%0d_msbf_bit%0d", c, k), dout_m, (k < 8) ? code[7-k] : 1'b0);
        chk($sformatf("ser%0d_lsbf_bit%0d", c, k), dout_l, (k < 8) ? code[k] : 1'b0);
        @(negedge dclk);
      end
    end

    // Enable drop mid-frame, resume, mid-frame input change, reset mid-frame.
    do_reset();
    mode     = 2'd1;
    lo_lim   = 8'h00;
    hi_lim   = 8'hFF;
    stepsize = 8'h11;
    wait_boundary(n);
    chk("en_first_sample", sample_m, 8'h11);
    repeat (3) @(negedge dclk);
    en    = 1'b0;
    lows  = 0;
    highs = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge dclk);
      if (dce_n_m !== 1'b1) lows++;
      if (j >= 5 && dout_m !== 1'b0) highs++;
    end
    chk("idle_dce_n_low_count", lows, 0);
    chk("idle_dout_high_count", highs, 0);
    chk("idle_sample_held", sample_m, 8'h11);
    en = 1'b1;
    @(negedge dclk);
    chk("resume_dce_n", dce_n_m, 0);
    chk("resume_sample", sample_m, 8'h22);
    repeat (2) @(negedge dclk);
    stepsize = 8'h50;
    repeat (4) @(negedge dclk);
    chk("midframe_sample_stable", sample_m, 8'h22);
    stepsize = 8'h11;
    wait_boundary(n);
    chk("midframe_gap", n, 4);
    chk("midframe_next_sample", sample_m, 8'h33);
    repeat (4) @(negedge dclk);
    rst = 1'b1;
    @(negedge dclk);
    chk("abort_sample", sample_m, 0);
    chk("abort_dce_n", dce_n_m, 1);
    chk("abort_dout", dout_m, 0);
    chk("abort_chirp_n", chirp_n_m, 1);
    rst = 1'b0;
    wait_boundary(n);
    chk("abort_restart_gap", n, 1);
    chk("abort_restart_sample", sample_m, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
